// File: rtl/vram_blitter.sv
// ---------------------------------------------------------------------------
// vram_blitter -- rectangular fill engine for planar VRAM.
//
// Writes a byte pattern into a rectangle of up to four 8 KB bit-planes that
// share the CPU-bus write port (0x8000-0xFFFF). Write slots are obtained via a
// bus_req/bus_gnt handshake; one write is emitted the cycle after each grant.
// Iteration order is plane (ascending), then column, then row; row and column
// wrap inside their plane.
//
// Optional feature: define BLIT_DITHER_EN to write pattern_odd on odd
// (absolute) rows; otherwise pattern_odd is ignored.
//
// Ports:
//   clk_24m      in   system clock (posedge)
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle fill request (sampled in IDLE only)
//   abort        in   stop after the in-flight write
//   plane_mask   in   [MAX_PLANES] planes to fill
//   col_start    in   [5] first byte column
//   col_count    in   [5] column count, 0 = 32
//   row_start    in   [8] first row
//   row_count    in   [8] row count, 0 = 256
//   pattern      in   [8] fill byte
//   pattern_odd  in   [8] fill byte for odd rows (dither build only)
//   bus_gnt      in   write slot granted this cycle
//   bus_req      out  requesting write slots
//   addr         out  [16] {1, plane[1:0], col[4:0], row[7:0]}
//   dout         out  [8] write data
//   we           out  write strobe
//   busy         out  fill in progress
//   done         out  one-cycle completion/abort pulse
// ---------------------------------------------------------------------------
module vram_blitter #(
   parameter int MAX_PLANES = 4
) (
   input  logic                  clk_24m,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [MAX_PLANES-1:0] plane_mask,
   input  logic [4:0]            col_start,
   input  logic [4:0]            col_count,
   input  logic [7:0]            row_start,
   input  logic [7:0]            row_count,
   input  logic [7:0]            pattern,
   input  logic [7:0]            pattern_odd,
   input  logic                  bus_gnt,
   output logic                  bus_req,
   output logic [15:0]           addr,
   output logic [7:0]            dout,
   output logic                  we,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t state, state_next;

   // Operands latched on start
   logic [MAX_PLANES-1:0] mask_l;
   logic [4:0]            col_start_l;
   logic [7:0]            row_start_l;
   logic [5:0]            cols_l;      // 1..32
   logic [8:0]            rows_l;      // 1..256
   logic [7:0]            pat_l;
`ifdef BLIT_DITHER_EN
   logic [7:0]            pat_odd_l;
`else
   logic                  unused_pattern_odd;
   assign unused_pattern_odd = ^pattern_odd;
`endif

   // Walk position
   logic [MAX_PLANES-1:0] mask_rem;    // planes not yet finished, incl. current
   logic [1:0]            plane;
   logic [4:0]            col;
   logic [7:0]            row;
   logic [5:0]            col_left;    // columns remaining incl. current
   logic [8:0]            row_left;    // rows remaining incl. current

   logic                  row_last;
   logic                  col_last;
   logic [MAX_PLANES-1:0] mask_next;
   logic                  last_write;

   // Lowest set bit of a plane mask (0 when the mask is empty)
   function automatic logic [1:0] low_plane(input logic [MAX_PLANES-1:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = MAX_PLANES - 1; i >= 0; i--) begin
         if (m[i]) begin
            r = 2'(i);
         end
      end
      return r;
   endfunction

   // End-of-row/column/plane detection for the current write position
   always_comb begin
      row_last   = (row_left == 9'd1);
      col_last   = (col_left == 6'd1);
      mask_next  = mask_rem & ~({{(MAX_PLANES-1){1'b0}}, 1'b1} << plane);
      last_write = row_last && col_last && (mask_next == '0);
   end

   // State register
   always_ff @(posedge clk_24m or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = SETUP;
            else       state_next = IDLE;
         end
         SETUP: begin
            if (abort || (mask_l == '0)) state_next = FINISH;
            else                         state_next = RUN;
         end
         RUN: begin
            // abort takes priority over a same-cycle grant: that slot is not used
            if (abort)                        state_next = FINISH;
            else if (bus_gnt && last_write)   state_next = FINISH;
            else                              state_next = RUN;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand latch, address walk and registered outputs
   always_ff @(posedge clk_24m or posedge reset) begin
      if (reset) begin
         mask_l      <= '0;
         col_start_l <= 5'd0;
         row_start_l <= 8'd0;
         cols_l      <= 6'd0;
         rows_l      <= 9'd0;
         pat_l       <= 8'd0;
`ifdef BLIT_DITHER_EN
         pat_odd_l   <= 8'd0;
`endif
         mask_rem    <= '0;
         plane       <= 2'd0;
         col         <= 5'd0;
         row         <= 8'd0;
         col_left    <= 6'd0;
         row_left    <= 9'd0;
         bus_req     <= 1'b0;
         addr        <= 16'd0;
         dout        <= 8'd0;
         we          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         we   <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mask_l      <= plane_mask;
                  col_start_l <= col_start;
                  row_start_l <= row_start;
                  cols_l      <= (col_count == 5'd0) ? 6'd32  : {1'b0, col_count};
                  rows_l      <= (row_count == 8'd0) ? 9'd256 : {1'b0, row_count};
                  pat_l       <= pattern;
`ifdef BLIT_DITHER_EN
                  pat_odd_l   <= pattern_odd;
`endif
                  busy        <= 1'b1;
               end
            end
            SETUP: begin
               if (!(abort || (mask_l == '0))) begin
                  mask_rem <= mask_l;
                  plane    <= low_plane(mask_l);
                  col      <= col_start_l;
                  row      <= row_start_l;
                  col_left <= cols_l;
                  row_left <= rows_l;
                  bus_req  <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  bus_req <= 1'b0;
               end else if (bus_gnt) begin
                  we   <= 1'b1;
                  addr <= {1'b1, plane, col, row};
`ifdef BLIT_DITHER_EN
                  dout <= row[0] ? pat_odd_l : pat_l;
`else
                  dout <= pat_l;
`endif
                  if (!row_last) begin
                     row      <= row + 8'd1;
                     row_left <= row_left - 9'd1;
                  end else begin
                     row      <= row_start_l;
                     row_left <= rows_l;
                     if (!col_last) begin
                        col      <= col + 5'd1;
                        col_left <= col_left - 6'd1;
                     end else begin
                        // next plane starts immediately from the latched origin
                        col      <= col_start_l;
                        col_left <= cols_l;
                        mask_rem <= mask_next;
                        plane    <= low_plane(mask_next);
                     end
                  end
                  if (last_write) begin
                     bus_req <= 1'b0;
                  end
               end
            end
            FINISH: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               bus_req <= 1'b0;
            end
            default: begin
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_blitter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for vram_blitter. Stimulus pushes the expected write
// stream (address, data) into a queue; a negedge monitor pops and compares on
// every we, and records first/last write and done timing.
// ---------------------------------------------------------------------------
module tb_vram_blitter;

   logic        clk_24m = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [3:0]  plane_mask;
   logic [4:0]  col_start;
   logic [4:0]  col_count;
   logic [7:0]  row_start;
   logic [7:0]  row_count;
   logic [7:0]  pattern;
   logic [7:0]  pattern_odd;
   logic        bus_gnt;
   logic        bus_req;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic        we;
   logic        busy;
   logic        done;

   vram_blitter #(.MAX_PLANES(4)) dut (
      .clk_24m(clk_24m), .reset(reset), .start(start), .abort(abort),
      .plane_mask(plane_mask), .col_start(col_start), .col_count(col_count),
      .row_start(row_start), .row_count(row_count), .pattern(pattern),
      .pattern_odd(pattern_odd), .bus_gnt(bus_gnt), .bus_req(bus_req),
      .addr(addr), .dout(dout), .we(we), .busy(busy), .done(done)
   );

   always #5 clk_24m = ~clk_24m;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   first_we = -1;
   int   last_we = -1;
   int   done_cyc = -1;
   int   done_cnt = 0;
   logic done_prev = 1'b0;
   logic gnt_at_edge = 1'b0;

   always @(posedge clk_24m) begin
      cyc         <= cyc + 1;
      gnt_at_edge <= bus_gnt;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compare every write against the scoreboard, track done timing
   always @(negedge clk_24m) begin
      if (!reset) begin
         if (we) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", addr, dout);
            end else begin
               mon_e = exp_q.pop_front();
               chk("wr_addr", {16'd0, addr}, {16'd0, mon_e.a});
               chk("wr_data", {24'd0, dout}, {24'd0, mon_e.d});
            end
            chk("we_after_gnt", {31'd0, gnt_at_edge}, 32'd1);
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy_low", {31'd0, busy}, 32'd0);
            chk("done_one_cycle", {31'd0, done_prev}, 32'd0);
         end
         done_prev = done;
      end
   end

   task automatic tick();
      @(posedge clk_24m);
      #1;
   endtask

   // Reference model: enumerate the rectangle directly from the fill rules
   function automatic int push_model(input logic [3:0] m, input int cs, input int cc,
                                     input int rs, input int rc,
                                     input logic [7:0] p, input logic [7:0] po);
      int   n;
      int   cols;
      int   rows;
      int   r_abs;
      int   c_abs;
      wr_t  e;
      n    = 0;
      cols = (cc == 0) ? 32 : cc;
      rows = (rc == 0) ? 256 : rc;
      for (int pl = 0; pl < 4; pl++) begin
         if (m[pl]) begin
            for (int c = 0; c < cols; c++) begin
               for (int r = 0; r < rows; r++) begin
                  r_abs = (rs + r) % 256;
                  c_abs = (cs + c) % 32;
                  e.a   = 16'(32'h8000 + pl * 32'h2000 + c_abs * 256 + r_abs);
`ifdef BLIT_DITHER_EN
                  e.d   = (r_abs % 2 == 1) ? po : p;
`else
                  e.d   = p;
`endif
                  exp_q.push_back(e);
                  n++;
               end
            end
         end
      end
      return n;
   endfunction

   task automatic set_ops(input logic [3:0] m, input logic [4:0] cs, input logic [4:0] cc,
                          input logic [7:0] rs, input logic [7:0] rc,
                          input logic [7:0] p, input logic [7:0] po);
      plane_mask = m;  col_start = cs;  col_count = cc;
      row_start  = rs; row_count = rc;  pattern   = p;  pattern_odd = po;
   endtask

   task automatic scramble_ops();
      plane_mask  = 4'($urandom);
      col_start   = 5'($urandom);
      col_count   = 5'($urandom);
      row_start   = 8'($urandom);
      row_count   = 8'($urandom);
      pattern     = 8'($urandom);
      pattern_odd = 8'($urandom);
   endtask

   // Run one fill with expected writes already queued (n of them)
   task automatic do_fill(input logic [3:0] m, input logic [4:0] cs, input logic [4:0] cc,
                          input logic [7:0] rs, input logic [7:0] rc,
                          input logic [7:0] p, input logic [7:0] po,
                          input int n, input bit rnd_gnt, input bit check_lat);
      int st;
      int dc;
      int budget;
      set_ops(m, cs, cc, rs, rc, p, po);
      start    = 1'b1;
      st       = cyc;
      dc       = done_cnt;
      first_we = -1;
      tick();
      start = 1'b0;
      scramble_ops();
      budget = n * 8 + 50;
      for (int i = 0; i < budget && done_cnt == dc; i++) begin
         bus_gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      bus_gnt = 1'b0;
      tick();
      chk("done_seen", done_cnt - dc, 32'd1);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      if (n > 0) chk("done_after_last_we", done_cyc - last_we, 32'd1);
      if (check_lat) begin
         if (n > 0) chk("first_we_latency", first_we - st, 32'd3);
         chk("done_latency", done_cyc - st, 3 + n);
      end
      exp_q.delete();
   endtask

   initial begin
      int   n;
      int   st;
      int   dc;
      wr_t  e;
      logic [15:0] wrap_addr[8];
      logic        gnt_pat[7];
      logic [3:0]  rm;
      logic [4:0]  rcs;
      logic [4:0]  rcc;
      logic [7:0]  rrs;
      logic [7:0]  rrc;
      logic [7:0]  rp;
      logic [7:0]  rpo;

      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      bus_gnt = 1'b0;
      set_ops(4'd0, 5'd0, 5'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      repeat (3) tick();
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_addr", {16'd0, addr}, 32'd0);
      chk("rst_dout", {24'd0, dout}, 32'd0);
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      // Wrap test: explicit expected address list
      wrap_addr = '{16'h9FFF, 16'h9F00, 16'h80FF, 16'h8000,
                    16'hDFFF, 16'hDF00, 16'hC0FF, 16'hC000};
      for (int i = 0; i < 8; i++) begin
         e.a = wrap_addr[i];
         e.d = 8'h5A;
         exp_q.push_back(e);
      end
      do_fill(4'b0101, 5'd31, 5'd2, 8'd255, 8'd2, 8'h5A, 8'h5A, 8, 1'b0, 1'b1);

      // Grant stall: 1 plane, 1 col, 4 rows, gnt pattern 1,0,0,1,0,1,1
      gnt_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      n = push_model(4'b0010, 3, 1, 10, 4, 8'h3C, 8'h3C);
      set_ops(4'b0010, 5'd3, 5'd1, 8'd10, 8'd4, 8'h3C, 8'h3C);
      dc = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < 7; k++) begin
         bus_gnt = gnt_pat[k];
         chk("stall_bus_req", {31'd0, bus_req}, 32'd1);
         tick();
      end
      bus_gnt = 1'b0;
      for (int i = 0; i < 20 && done_cnt == dc; i++) tick();
      tick();
      chk("stall_done", done_cnt - dc, 32'd1);
      chk("stall_queue", exp_q.size(), 32'd0);
      chk("stall_bus_req_off", {31'd0, bus_req}, 32'd0);
      exp_q.delete();

      // Abort after 3 writes of a 100-write fill, plus a start while busy
      n = push_model(4'b0001, 0, 10, 0, 10, 8'h77, 8'h77);
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      set_ops(4'b0001, 5'd0, 5'd10, 8'd0, 8'd10, 8'h77, 8'h77);
      dc = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      bus_gnt = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      bus_gnt = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 20 && done_cnt == dc; i++) tick();
      bus_gnt = 1'b1;
      repeat (20) tick();
      bus_gnt = 1'b0;
      chk("abort_done", done_cnt - dc, 32'd1);
      chk("abort_writes", exp_q.size(), 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();

      // Zero mask: no writes, done 3 cycles after start
      do_fill(4'b0000, 5'd7, 5'd3, 8'd9, 8'd4, 8'hFF, 8'hFF, 0, 1'b0, 1'b1);

      // Randomized fills against the model with random grants
      for (int t = 0; t < 8; t++) begin
         rm  = 4'($urandom_range(0, 15));
         rcs = 5'($urandom);
         rcc = (t == 7) ? 5'd0 : 5'($urandom_range(1, 3));
         rrs = 8'($urandom);
         rrc = 8'($urandom_range(0, 6));
         rp  = 8'($urandom);
         rpo = 8'($urandom);
         if (t == 7) rm = 4'b1000;
         if (rrc == 8'd0 && rcc == 5'd0) rrc = 8'd2;
         n = push_model(rm, int'(rcs), int'(rcc), int'(rrs), int'(rrc), rp, rpo);
         do_fill(rm, rcs, rcc, rrs, rrc, rp, rpo, n, 1'b1, 1'b0);
      end

      // Dither rows 5,6,7
      n = push_model(4'b0001, 2, 1, 5, 3, 8'h11, 8'hEE);
      do_fill(4'b0001, 5'd2, 5'd1, 8'd5, 8'd3, 8'h11, 8'hEE, n, 1'b0, 1'b1);

      // Reset mid-fill: outputs clear asynchronously, no done
      n = push_model(4'b0011, 0, 4, 0, 50, 8'h42, 8'h24);
      set_ops(4'b0011, 5'd0, 5'd4, 8'd0, 8'd50, 8'h42, 8'h24);
      start = 1'b1;
      tick();
      start = 1'b0;
      bus_gnt = 1'b1;
      repeat (20) tick();
      dc = done_cnt;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_we", {31'd0, we}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("mid_rst_addr", {16'd0, addr}, 32'd0);
      chk("mid_rst_dout", {24'd0, dout}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      exp_q.delete();
      bus_gnt = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (6) tick();
      chk("mid_rst_no_done", done_cnt - dc, 32'd0);

      // Full-screen fill: 32768 writes of 0xAA
      n = push_model(4'b1111, 0, 0, 0, 0, 8'hAA, 8'hAA);
      chk("full_count", n, 32'd32768);
      do_fill(4'b1111, 5'd0, 5'd0, 8'd0, 8'd0, 8'hAA, 8'hAA, n, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
